// File: rtl/ls_agu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ls_agu_pipe_pkg
//  Purpose  : Shared constants, instruction-ID codes and the load/store
//             decode helper for the pipelined local-store address unit.
//             Includes the lqx/lqr/stqx/stqr codes alongside lqa/lqd/stqa/stqd.
//  Revision : 1.0 - initial release
// ============================================================================
package ls_agu_pipe_pkg;

  // Local-store accesses are quadword aligned: low 4 address bits cleared.
  localparam int QW_ALIGN_BITS = 4;

  localparam logic [6:0] INSTR_ID_LQD  = 7'h10;
  localparam logic [6:0] INSTR_ID_LQA  = 7'h11;
  localparam logic [6:0] INSTR_ID_LQX  = 7'h12;
  localparam logic [6:0] INSTR_ID_LQR  = 7'h13;
  localparam logic [6:0] INSTR_ID_STQD = 7'h14;
  localparam logic [6:0] INSTR_ID_STQA = 7'h15;
  localparam logic [6:0] INSTR_ID_STQX = 7'h16;
  localparam logic [6:0] INSTR_ID_STQR = 7'h17;

  // Addressing form: d = RA+I10<<4, a = I16<<2, x = RA+RB, r = PC+I16<<2
  typedef enum logic [1:0] {
    EA_FORM_D = 2'd0,
    EA_FORM_A = 2'd1,
    EA_FORM_X = 2'd2,
    EA_FORM_R = 2'd3
  } ea_form_e;

  typedef struct packed {
    logic     is_ls;
    logic     is_store;
    ea_form_e form;
  } ls_dec_t;

  function automatic ls_dec_t decode_instr(input logic [6:0] id);
    ls_dec_t d;
    d.is_ls    = 1'b1;
    d.is_store = 1'b0;
    d.form     = EA_FORM_D;
    case (id)
      INSTR_ID_LQD:  d.form = EA_FORM_D;
      INSTR_ID_LQA:  d.form = EA_FORM_A;
      INSTR_ID_LQX:  d.form = EA_FORM_X;
      INSTR_ID_LQR:  d.form = EA_FORM_R;
      INSTR_ID_STQD: begin d.is_store = 1'b1; d.form = EA_FORM_D; end
      INSTR_ID_STQA: begin d.is_store = 1'b1; d.form = EA_FORM_A; end
      INSTR_ID_STQX: begin d.is_store = 1'b1; d.form = EA_FORM_X; end
      INSTR_ID_STQR: begin d.is_store = 1'b1; d.form = EA_FORM_R; end
      default:       d.is_ls = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ls_agu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : ls_agu_pipe_if
//  Purpose  : Issue-side and local-store-side signal bundle of ls_agu_pipe.
//             master = issuing logic / bench, slave = the address pipeline.
//             Vectors use big-endian numbering [0:N-1].
//  Revision : 1.0 - initial release
// ============================================================================
interface ls_agu_pipe_if #(
  parameter int LS_ADDR_W = 15,
  parameter int TAG_W     = 7,
  parameter int DATA_W    = 128
);
  logic                 valid_in;
  logic [0:6]           instr_id;
  logic [0:127]         ra_data;
  logic [0:127]         rb_data;
  logic [0:DATA_W-1]    rt_data;
  logic [0:31]          pc;
  logic [0:9]           imme10;
  logic [0:15]          imme16;
  logic [0:TAG_W-1]     tag_in;
  logic                 stall;
  logic                 flush;
  logic                 addr_valid;
  logic [0:LS_ADDR_W-1] addr_result;
  logic                 is_store;
  logic [0:DATA_W-1]    st_data;
  logic [0:TAG_W-1]     tag_out;
  logic                 addr_oor;

  modport master (
    output valid_in, instr_id, ra_data, rb_data, rt_data, pc, imme10, imme16,
           tag_in, stall, flush,
    input  addr_valid, addr_result, is_store, st_data, tag_out, addr_oor
  );

  modport slave (
    input  valid_in, instr_id, ra_data, rb_data, rt_data, pc, imme10, imme16,
           tag_in, stall, flush,
    output addr_valid, addr_result, is_store, st_data, tag_out, addr_oor
  );
endinterface
`default_nettype wire

// File: rtl/ls_agu_pipe_ea_calc.sv
`default_nettype none
// ============================================================================
//  Module   : ls_agu_pipe_ea_calc
//  Purpose  : Combinational 32-bit effective-address calculation and
//             load/store decode for the lq*/stq* family.
//  Revision : 1.0 - initial release
// ============================================================================
module ls_agu_pipe_ea_calc
  import ls_agu_pipe_pkg::*;
(
  input  logic [0:6]  instr_id,
  input  logic [0:31] ra,
  input  logic [0:31] rb,
  input  logic [0:31] pc,
  input  logic [0:9]  imme10,
  input  logic [0:15] imme16,
  output logic [0:31] ea,
  output logic        is_store,
  output logic        is_ls
);
  ls_dec_t     dec;
  logic [0:31] off_i10;
  logic [0:31] off_i16;

  assign dec      = decode_instr(instr_id);
  assign off_i10  = {{18{imme10[0]}}, imme10, 4'b0000};
  assign off_i16  = {{14{imme16[0]}}, imme16, 2'b00};
  assign is_store = dec.is_store;
  assign is_ls    = dec.is_ls;

  // Select the addressing form; every sum wraps modulo 2^32
  always_comb begin
    ea = '0;
    case (dec.form)
      EA_FORM_D: ea = ra + off_i10;
      EA_FORM_A: ea = off_i16;
      EA_FORM_X: ea = ra + rb;
      EA_FORM_R: ea = pc + off_i16;
      default:   ea = '0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/ls_agu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ls_agu_pipe
//  Purpose  : Pipelined quadword-aligned local-store address unit. Carries
//             tag and store data with each address through STAGES registers,
//             with stall (hold), flush (drop in-flight) and sync reset.
//             Optional macro LS_OOR_FLAG_EN builds the address-wrap flag.
//  Revision : 1.0 - initial release
// ============================================================================
module ls_agu_pipe
  import ls_agu_pipe_pkg::*;
#(
  parameter int LS_ADDR_W = 15,
  parameter int STAGES    = 2,
  parameter int TAG_W     = 7,
  parameter int DATA_W    = 128
) (
  input  logic         clk,
  input  logic         rst,
  ls_agu_pipe_if.slave bus
);
  localparam int LAST = STAGES - 1;

  logic [0:31]          ea;
  logic                 ea_store;
  logic                 ea_ls;
  logic [0:LS_ADDR_W-1] head_addr;
  logic                 head_oor;
  logic                 unused_hi;
  logic                 unused_bits;

  ls_agu_pipe_ea_calc u_ea_calc (
    .instr_id (bus.instr_id),
    .ra       (bus.ra_data[0:31]),
    .rb       (bus.rb_data[0:31]),
    .pc       (bus.pc),
    .imme10   (bus.imme10),
    .imme16   (bus.imme16),
    .ea       (ea),
    .is_store (ea_store),
    .is_ls    (ea_ls)
  );

  // Local-store address is the low LS_ADDR_W bits of EA, quadword aligned
  assign head_addr = {ea[32-LS_ADDR_W:31-QW_ALIGN_BITS], {QW_ALIGN_BITS{1'b0}}};

`ifdef LS_OOR_FLAG_EN
  assign head_oor  = |ea[0:31-LS_ADDR_W];
  assign unused_hi = 1'b0;
`else
  assign head_oor  = 1'b0;
  assign unused_hi = ^ea[0:31-LS_ADDR_W];
`endif

  assign unused_bits = ^{bus.ra_data[32:127], bus.rb_data[32:127],
                         ea[32-QW_ALIGN_BITS:31], unused_hi};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic                 v;
    logic                 st;
    logic                 oor;
    logic [0:LS_ADDR_W-1] addr;
    logic [0:TAG_W-1]     tag;
    logic [0:DATA_W-1]    data;
    logic                 nxt_v;
    logic                 nxt_st;
    logic                 nxt_oor;
    logic [0:LS_ADDR_W-1] nxt_addr;
    logic [0:TAG_W-1]     nxt_tag;
    logic [0:DATA_W-1]    nxt_data;

    if (s == 0) begin : g_head
      // Unsupported IDs enter as bubbles
      assign nxt_v    = bus.valid_in & ea_ls;
      assign nxt_st   = ea_store;
      assign nxt_oor  = head_oor;
      assign nxt_addr = head_addr;
      assign nxt_tag  = bus.tag_in;
      assign nxt_data = bus.rt_data;
    end else begin : g_tail
      assign nxt_v    = g_stage[s-1].v;
      assign nxt_st   = g_stage[s-1].st;
      assign nxt_oor  = g_stage[s-1].oor;
      assign nxt_addr = g_stage[s-1].addr;
      assign nxt_tag  = g_stage[s-1].tag;
      assign nxt_data = g_stage[s-1].data;
    end

    // Stage register: advance unless stalled; flush clears only the valid bit
    always_ff @(posedge clk) begin
      if (rst) begin
        v    <= 1'b0;
        st   <= 1'b0;
        oor  <= 1'b0;
        addr <= '0;
        tag  <= '0;
        data <= '0;
      end else begin
        if (bus.flush) begin
          v <= 1'b0;
        end else if (!bus.stall) begin
          v <= nxt_v;
        end
        if (!bus.stall) begin
          st   <= nxt_st;
          oor  <= nxt_oor;
          addr <= nxt_addr;
          tag  <= nxt_tag;
          data <= nxt_data;
        end
      end
    end
  end

  // Sideband fields read zero whenever the output entry is empty
  assign bus.addr_valid  = g_stage[LAST].v;
  assign bus.addr_result = g_stage[LAST].v ? g_stage[LAST].addr : '0;
  assign bus.is_store    = g_stage[LAST].v & g_stage[LAST].st;
  assign bus.addr_oor    = g_stage[LAST].v & g_stage[LAST].oor;
  assign bus.tag_out     = g_stage[LAST].v ? g_stage[LAST].tag : '0;
  assign bus.st_data     = g_stage[LAST].data;
endmodule
`default_nettype wire

// File: tb/tb_ls_agu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ls_agu_pipe
//  Purpose  : Self-checking bench for ls_agu_pipe. Three instances share one
//             stimulus stream: (STAGES=2, W=15), (STAGES=1, W=15),
//             (STAGES=4, W=18). A queue-based reference model per instance
//             predicts every output cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ls_agu_pipe;
  import ls_agu_pipe_pkg::*;

  localparam int N = 3;

  function automatic int stg_of(int k);
    return (k == 1) ? 1 : (k == 2) ? 4 : 2;
  endfunction

  function automatic int aw_of(int k);
    return (k == 2) ? 18 : 15;
  endfunction

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [6:0]   instr_id;
  logic [127:0] ra;
  logic [127:0] rb;
  logic [127:0] rt;
  logic [31:0]  pc;
  logic [9:0]   i10;
  logic [15:0]  i16;
  logic [6:0]   tag;
  logic         stall;
  logic         flush;

  logic         obs_v    [N];
  logic [31:0]  obs_addr [N];
  logic         obs_st   [N];
  logic         obs_oor  [N];
  logic [6:0]   obs_tag  [N];
  logic [127:0] obs_data [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int S = stg_of(k);
    localparam int W = aw_of(k);
    ls_agu_pipe_if #(.LS_ADDR_W(W), .TAG_W(7), .DATA_W(128)) bus ();
    assign bus.valid_in = valid_in;
    assign bus.instr_id = instr_id;
    assign bus.ra_data  = ra;
    assign bus.rb_data  = rb;
    assign bus.rt_data  = rt;
    assign bus.pc       = pc;
    assign bus.imme10   = i10;
    assign bus.imme16   = i16;
    assign bus.tag_in   = tag;
    assign bus.stall    = stall;
    assign bus.flush    = flush;
    ls_agu_pipe #(.LS_ADDR_W(W), .STAGES(S), .TAG_W(7), .DATA_W(128)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
    assign obs_v[k]    = bus.addr_valid;
    assign obs_addr[k] = 32'(bus.addr_result);
    assign obs_st[k]   = bus.is_store;
    assign obs_oor[k]  = bus.addr_oor;
    assign obs_tag[k]  = bus.tag_out;
    assign obs_data[k] = bus.st_data;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int           age;
    logic [31:0]  addr;
    logic         st;
    logic         oor;
    logic [6:0]   tag;
    logic [127:0] data;
  } ent_t;

  typedef logic [169:0] pk_t;

  ent_t mq [N][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Effective address straight from the addressing rules
  function automatic bit ref_op(output logic [31:0] ea, output logic st);
    logic [31:0] o10;
    logic [31:0] o16;
    o10 = 32'(int'($signed(i10)) * 16);
    o16 = 32'(int'($signed(i16)) * 4);
    ea  = 32'd0;
    st  = 1'b0;
    ref_op = 1'b1;
    case (instr_id)
      INSTR_ID_LQD:  ea = ra[127:96] + o10;
      INSTR_ID_LQA:  ea = o16;
      INSTR_ID_LQX:  ea = ra[127:96] + rb[127:96];
      INSTR_ID_LQR:  ea = pc + o16;
      INSTR_ID_STQD: begin ea = ra[127:96] + o10;        st = 1'b1; end
      INSTR_ID_STQA: begin ea = o16;                     st = 1'b1; end
      INSTR_ID_STQX: begin ea = ra[127:96] + rb[127:96]; st = 1'b1; end
      INSTR_ID_STQR: begin ea = pc + o16;                st = 1'b1; end
      default:       ref_op = 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] id_of(int r);
    case (r)
      0: return INSTR_ID_LQD;
      1: return INSTR_ID_LQA;
      2: return INSTR_ID_LQX;
      3: return INSTR_ID_LQR;
      4: return INSTR_ID_STQD;
      5: return INSTR_ID_STQA;
      6: return INSTR_ID_STQX;
      7: return INSTR_ID_STQR;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic pk_t exp_of(int k);
    if (mq[k].size() > 0 && mq[k][0].age == stg_of(k))
      return {1'b1, mq[k][0].addr, mq[k][0].st, mq[k][0].oor, mq[k][0].tag, mq[k][0].data};
    return '0;
  endfunction

  function automatic pk_t obs_of(int k);
    return {obs_v[k], obs_addr[k], obs_st[k], obs_oor[k], obs_tag[k],
            (obs_v[k] === 1'b1) ? obs_data[k] : 128'd0};
  endfunction

  // One clock edge; the model consumes the inputs seen at that edge
  task automatic tick();
    logic [31:0] ea;
    logic        st;
    bit          ok;
    ent_t        e;
    @(posedge clk);
    ok = ref_op(ea, st);
    for (int k = 0; k < N; k++) begin
      if (rst || flush) begin
        mq[k].delete();
      end else if (!stall) begin
        for (int i = 0; i < mq[k].size(); i++) begin
          e = mq[k][i];
          e.age++;
          mq[k][i] = e;
        end
        while (mq[k].size() > 0 && mq[k][0].age > stg_of(k)) void'(mq[k].pop_front());
        if (valid_in && ok) begin
          e.age  = 1;
          e.addr = ea & ((32'd1 << aw_of(k)) - 32'd1) & ~32'hF;
          e.st   = st;
          e.tag  = tag;
          e.data = rt;
`ifdef LS_OOR_FLAG_EN
          e.oor  = (ea >> aw_of(k)) != 32'd0;
`else
          e.oor  = 1'b0;
`endif
          mq[k].push_back(e);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive_rand(input logic [6:0] id, input logic [6:0] t);
    valid_in = 1'b1;
    instr_id = id;
    ra  = {$urandom, $urandom, $urandom, $urandom};
    rb  = {$urandom, $urandom, $urandom, $urandom};
    rt  = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 1) == 0) begin
      ra[127:96] = $urandom & 32'h7FFF;
      rb[127:96] = $urandom & 32'h3FFF;
    end
    pc  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF) : $urandom;
    i10 = 10'($urandom);
    i16 = 16'($urandom);
    tag = t;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({obs_v[k], obs_addr[k], obs_st[k], obs_oor[k], obs_tag[k], obs_data[k]} !== 170'd0) begin
        errors++;
        $display("FAIL reset k=%0d got=%h want=0", k,
                 {obs_v[k], obs_addr[k], obs_st[k], obs_oor[k], obs_tag[k], obs_data[k]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [31:0]  w15, w18, wa;
    logic         wst, woor;
    logic [6:0]   wtag;
    logic [127:0] wdat;
    for (int j = 0; j < 4; j++) begin
      drive_rand(7'h00, 7'h40 + 7'(j));
      wst = (j == 1) || (j == 3);
      case (j)
        0: begin instr_id = INSTR_ID_LQD;  ra[127:96] = 32'h100; i10 = 10'h3FF;
                 w15 = 32'h0F0;  w18 = 32'h0F0; end
        1: begin instr_id = INSTR_ID_STQX; ra[127:96] = 32'h7FF5; rb[127:96] = 32'h1F;
                 w15 = 32'h010;  w18 = 32'h08010; end
        2: begin instr_id = INSTR_ID_LQR;  pc = 32'h200; i16 = 16'hFFFF;
                 w15 = 32'h1F0;  w18 = 32'h1F0; end
        default: begin instr_id = INSTR_ID_STQA; i16 = 16'h1234;
                 w15 = 32'h48D0; w18 = 32'h48D0; end
      endcase
      wtag = tag;
      wdat = rt;
      for (int t = 1; t <= 5; t++) begin
        tick();
        valid_in = 1'b0;
        for (int k = 0; k < N; k++) begin
          checks++;
          if (obs_of(k) !== exp_of(k)) begin
            errors++;
            $display("FAIL spec_model k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_of(k), exp_of(k));
          end
          if (t == stg_of(k)) begin
            wa = (k == 2) ? w18 : w15;
`ifdef LS_OOR_FLAG_EN
            woor = (j == 1) && (k != 2);
`else
            woor = 1'b0;
`endif
            checks++;
            if ({obs_v[k], obs_addr[k], obs_st[k], obs_oor[k], obs_tag[k], obs_data[k]} !==
                {1'b1, wa, wst, woor, wtag, wdat}) begin
              errors++;
              $display("FAIL spec_vec%0d k=%0d got addr=%h v=%b st=%b oor=%b tag=%h want addr=%h st=%b oor=%b tag=%h",
                       j, k, obs_addr[k], obs_v[k], obs_st[k], obs_oor[k], obs_tag[k], wa, wst, woor, wtag);
            end
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [6:0] seen [N][$];
    bit         ok;
    for (int c = 0; c < 14; c++) begin
      stall = 1'b0;
      case (c)
        0:       drive_rand(id_of($urandom_range(0, 7)), 7'd1);
        1:       begin drive_rand(id_of($urandom_range(0, 7)), 7'd2); stall = 1'b1; end
        2, 3:    stall = 1'b1;
        4:       ;
        5:       drive_rand(id_of($urandom_range(0, 7)), 7'd3);
        6:       drive_rand(id_of($urandom_range(0, 7)), 7'd4);
        default: valid_in = 1'b0;
      endcase
      tick();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs_of(k) !== exp_of(k)) begin
          errors++;
          $display("FAIL stall_model k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_of(k), exp_of(k));
        end
        if (obs_v[k] === 1'b1 && (seen[k].size() == 0 || seen[k][$] != obs_tag[k]))
          seen[k].push_back(obs_tag[k]);
      end
    end
    stall = 1'b0;
    for (int k = 0; k < N; k++) begin
      ok = (seen[k].size() == 4);
      for (int j = 0; j < seen[k].size(); j++) ok = ok && (seen[k][j] == 7'(j + 1));
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL stall_order k=%0d got %0d distinct entries want 4 in order 1..4", k, seen[k].size());
      end
    end
  endtask

  task automatic test_flush_or_rst(input bit use_rst);
    for (int c = 0; c < 7; c++) begin
      case (c)
        0, 1:    drive_rand(id_of($urandom_range(0, 7)), 7'(8 + c));
        2:       begin drive_rand(id_of($urandom_range(0, 7)), 7'd10);
                   if (use_rst) rst = 1'b1; else flush = 1'b1; end
        default: valid_in = 1'b0;
      endcase
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs_of(k) !== exp_of(k)) begin
          errors++;
          $display("FAIL %s_model k=%0d cyc=%0d got=%h want=%h", use_rst ? "rst" : "flush",
                   k, cyc, obs_of(k), exp_of(k));
        end
        if (c >= 2 && (c - 2) < stg_of(k)) begin
          checks++;
          if (use_rst && {obs_v[k], obs_addr[k], obs_st[k], obs_oor[k], obs_tag[k], obs_data[k]} !== 170'd0) begin
            errors++;
            $display("FAIL rst_mid_zero k=%0d got v=%b addr=%h tag=%h want all 0", k, obs_v[k], obs_addr[k], obs_tag[k]);
          end else if (!use_rst && obs_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill k=%0d t=%0d got v=%b want 0", k, c - 1, obs_v[k]);
          end
        end
      end
    end
  endtask

  task automatic test_unsupported();
    int nv [N];
    for (int k = 0; k < N; k++) nv[k] = 0;
    drive_rand(7'h7F, 7'h55);
    for (int c = 0; c < 6; c++) begin
      tick();
      valid_in = 1'b0;
      for (int k = 0; k < N; k++) if (obs_v[k] !== 1'b0) nv[k]++;
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (nv[k] != 0) begin
        errors++;
        $display("FAIL unsupported k=%0d got %0d valid cycles want 0", k, nv[k]);
      end
    end
  endtask

  task automatic test_random();
    bit held;
    held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        if ($urandom_range(0, 9) < 8) drive_rand(id_of($urandom_range(0, 8)), 7'($urandom));
        else valid_in = 1'b0;
      end
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 24) == 0);
      held  = stall;
      tick();
      flush = 1'b0;
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs_of(k) !== exp_of(k)) begin
          errors++;
          $display("FAIL random k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_of(k), exp_of(k));
        end
      end
    end
    stall    = 1'b0;
    valid_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; instr_id = 7'h00; ra = '0; rb = '0; rt = '0;
    pc = '0; i10 = '0; i16 = '0; tag = '0; stall = 1'b0; flush = 1'b0;
    #2;
    test_reset();
    test_spec_vectors();
    test_stall();
    test_flush_or_rst(1'b0);
    test_flush_or_rst(1'b1);
    test_unsupported();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
